// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lends one shared, externally pipelined adder to NREQ
// requesters, one transaction at a time, and returns the captured sum with its owner id.
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 2,
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W:0]        add_sum,
    output logic              rsp_valid,
    output logic [2:0]        rsp_id,
    output logic [W:0]        rsp_sum,
    output logic              busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state_reg;
    logic [2:0] ptr_reg;
    logic [2:0] cnt_reg;
    logic [2:0] win_next;
    logic [2:0] ptr_next;
    logic       found_next;
    logic [3:0] idx_next;
    logic [7:0] req_ext;
    logic [W-1:0] opa_arr [8];
    logic [W-1:0] opb_arr [8];

    // Widen to eight slots so every 3-bit index is in range for any legal NREQ.
    assign req_ext = 8'(req);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
            if (gi < NREQ) begin : g_used
                assign opa_arr[gi] = op_a[gi*W +: W];
                assign opb_arr[gi] = op_b[gi*W +: W];
            end else begin : g_unused
                assign opa_arr[gi] = '0;
                assign opb_arr[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        win_next   = '0;
        found_next = 1'b0;
        idx_next   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_next = {1'b0, ptr_reg} + 4'(k);
            if (idx_next >= 4'(NREQ))
                idx_next = idx_next - 4'(NREQ);
            if (!found_next && req_ext[idx_next[2:0]]) begin
                found_next = 1'b1;
                win_next   = idx_next[2:0];
            end
        end
        ptr_next = (win_next == 3'(NREQ-1)) ? 3'd0 : win_next + 3'd1;
    end

    assign busy = (state_reg == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            gnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    gnt       <= '0;
                    if (found_next) begin
                        gnt       <= NREQ'(1) << win_next;
                        add_a     <= opa_arr[win_next];
                        add_b     <= opb_arr[win_next];
                        rsp_id    <= win_next;
                        ptr_reg   <= ptr_next;
                        cnt_reg   <= '0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    gnt <= '0;
                    // cnt_reg holds (edges since grant - 1); capture lands on edge G+1+ADD_LAT.
                    if (cnt_reg == 3'(ADD_LAT)) begin
                        rsp_sum   <= add_sum;
                        rsp_valid <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed table, multi-cycle corner sequences and randomized
// transactions checked against a round-robin reference model; second instance uses ADD_LAT=3.
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] op_a = '0, op_b = '0;
    logic [3:0] gnt;
    logic [1:0] add_a, add_b;
    logic [2:0] add_sum;
    logic       rsp_valid, busy;
    logic [2:0] rsp_id, rsp_sum;

    logic [3:0] req3 = '0;
    logic [7:0] op_a3 = '0, op_b3 = '0;
    logic [3:0] gnt3;
    logic [1:0] add_a3, add_b3;
    logic [2:0] add_sum3;
    logic       rsp_valid3, busy3;
    logic [2:0] rsp_id3, rsp_sum3;

    int n_chk = 0;
    int n_fail = 0;
    int m_ptr = 0;
    int txn = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.NREQ(4), .W(2), .ADD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy));

    adder_arbiter #(.NREQ(4), .W(2), .ADD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .op_a(op_a3), .op_b(op_b3), .gnt(gnt3),
        .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3), .rsp_valid(rsp_valid3),
        .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .busy(busy3));

    // External adders: one register stage per unit of latency.
    logic [2:0] sum_p;
    logic [2:0] s3 [3];
    always @(posedge clk) sum_p <= {1'b0, add_a} + {1'b0, add_b};
    assign add_sum = sum_p;
    always @(posedge clk) begin
        s3[0] <= {1'b0, add_a3} + {1'b0, add_b3};
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end
    assign add_sum3 = s3[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, exp);
        end
    endtask

    function automatic int model_winner(input logic [3:0] mask);
        for (int k = 0; k < 4; k++)
            if (mask[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic int slice(input logic [7:0] v, input int i);
        return int'((v >> (2*i)) & 8'h3);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; req3 = '0;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic do_txn(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b,
                          input int eid, input int esum);
        int edges, lat;
        bit got, seen, stable;
        txn++;
        @(negedge clk);
        req = mask; op_a = a; op_b = b;
        edges = 0; got = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1; edges++;
            if (gnt != 0) got = 1;
        end
        chk("grant seen", 32'(got), 1);
        if (!got) begin req = '0; return; end
        chk("grant on first edge", edges, 1);
        chk("gnt onehot", 32'(gnt), 32'(1 << eid));
        chk("busy at G", 32'(busy), 1);
        chk("add_a at G", 32'(add_a), slice(a, eid));
        chk("add_b at G", 32'(add_b), slice(b, eid));
        req = '0; op_a = 8'($urandom); op_b = 8'($urandom);
        lat = 0; seen = 0; stable = 1;
        while (!seen && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) chk("gnt low G+1", 32'(gnt), 0);
            if (add_a !== 2'(slice(a, eid)) || add_b !== 2'(slice(b, eid))) stable = 0;
            if (rsp_valid) seen = 1;
        end
        chk("operands stable", 32'(stable), 1);
        chk("rsp latency", lat, 2);
        chk("rsp_id", 32'(rsp_id), eid);
        chk("rsp_sum", 32'(rsp_sum), esum);
        @(posedge clk); #1;
        chk("rsp_valid drop", 32'(rsp_valid), 0);
        chk("rsp_sum hold", 32'(rsp_sum), esum);
        chk("busy idle", 32'(busy), 0);
        m_ptr = (eid + 1) % 4;
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [7:0] a;
        logic [7:0] b;
        int         eid;
        int         esum;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int order [4];
        int when [4];
        int sums [4];
        int ng, nr, e, w, es;
        logic [3:0] m;
        logic [7:0] ra, rb;
        bit got;

        vecs[0] = '{4'b0001, {2'd0,2'd0,2'd0,2'd1}, {2'd0,2'd0,2'd0,2'd1}, 0, 2};
        vecs[1] = '{4'b0100, {2'd0,2'd3,2'd0,2'd0}, {2'd0,2'd3,2'd0,2'd0}, 2, 6};
        vecs[2] = '{4'b1001, {2'd1,2'd0,2'd0,2'd2}, {2'd2,2'd0,2'd0,2'd1}, 3, 3};
        vecs[3] = '{4'b1001, {2'd1,2'd0,2'd0,2'd2}, {2'd2,2'd0,2'd0,2'd1}, 0, 3};
        vecs[4] = '{4'b1111, {2'd3,2'd2,2'd1,2'd0}, {2'd3,2'd2,2'd1,2'd0}, 1, 2};
        vecs[5] = '{4'b0001, {2'd3,2'd3,2'd3,2'd0}, {2'd3,2'd3,2'd3,2'd0}, 0, 0};
        vecs[6] = '{4'b1000, {2'd3,2'd0,2'd0,2'd0}, {2'd3,2'd0,2'd0,2'd0}, 3, 6};

        #12;
        chk("reset gnt", 32'(gnt), 0);
        chk("reset add_a", 32'(add_a), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_id", 32'(rsp_id), 0);
        chk("reset rsp_sum", 32'(rsp_sum), 0);
        chk("reset busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].mask, vecs[i].a, vecs[i].b, vecs[i].eid, vecs[i].esum);

        // All four requesters held; each drops its request after its grant.
        do_reset();
        txn++;
        op_a = {2'd3,2'd2,2'd1,2'd0}; op_b = {2'd3,2'd2,2'd1,2'd0};
        req = 4'b1111;
        ng = 0; nr = 0; e = 0;
        while ((ng < 4 || nr < 4) && e < 60) begin
            @(posedge clk); #1; e++;
            if (gnt != 0 && ng < 4) begin
                for (int k = 0; k < 4; k++) if (gnt[k]) order[ng] = k;
                when[ng] = e; ng++;
                req = req & ~gnt;
            end
            if (rsp_valid && nr < 4) begin sums[nr] = int'(rsp_sum); nr++; end
        end
        chk("rr grants seen", ng, 4);
        chk("rr rsps seen", nr, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) chk("rr order", order[k], k);
            if (k < nr) chk("rr sum", sums[k], 2*k);
            if (k > 0 && k < ng) chk("rr spacing", when[k] - when[k-1], 3);
        end
        m_ptr = 0;

        // Reset while waiting aborts the response and restarts search from 0.
        do_reset();
        txn++;
        @(negedge clk);
        req = 4'b0010; op_a = {2'd0,2'd0,2'd1,2'd0}; op_b = {2'd0,2'd0,2'd2,2'd0};
        got = 0; e = 0;
        while (!got && e < 20) begin @(posedge clk); #1; e++; if (gnt != 0) got = 1; end
        chk("abort grant", 32'(gnt), 32'(4'b0010));
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("abort gnt", 32'(gnt), 0);
        chk("abort add_a", 32'(add_a), 0);
        chk("abort add_b", 32'(add_b), 0);
        chk("abort rsp_valid", 32'(rsp_valid), 0);
        chk("abort rsp_id", 32'(rsp_id), 0);
        chk("abort rsp_sum", 32'(rsp_sum), 0);
        chk("abort busy", 32'(busy), 0);
        @(negedge clk); rst = 1'b0;
        m_ptr = 0;
        got = 0;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (rsp_valid) got = 1; end
        chk("no rsp after abort", 32'(got), 0);
        do_txn(4'b0110, {2'd0,2'd2,2'd1,2'd0}, {2'd0,2'd1,2'd1,2'd0}, 1, 2);

        // Randomized traffic against the round-robin model, with idle gaps.
        for (int i = 0; i < 40; i++) begin
            m  = 4'($urandom_range(1, 15));
            ra = 8'($urandom);
            rb = 8'($urandom);
            w  = model_winner(m);
            es = slice(ra, w) + slice(rb, w);
            do_txn(m, ra, rb, w, es);
            if (i % 8 == 3) begin
                req = '0;
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk); #1;
                    chk("idle gnt", 32'(gnt), 0);
                    chk("idle busy", 32'(busy), 0);
                end
            end
        end

        // Latency-3 instance.
        txn++;
        @(negedge clk);
        req3 = 4'b0001; op_a3 = 8'd2; op_b3 = 8'd1;
        got = 0; e = 0;
        while (!got && e < 20) begin @(posedge clk); #1; e++; if (gnt3 != 0) got = 1; end
        chk("lat3 grant", 32'(gnt3), 1);
        chk("lat3 busy G", 32'(busy3), 1);
        req3 = '0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                chk("lat3 no rsp yet", 32'(rsp_valid3), 0);
                chk("lat3 busy", 32'(busy3), 1);
            end else begin
                chk("lat3 rsp_valid", 32'(rsp_valid3), 1);
                chk("lat3 rsp_sum", 32'(rsp_sum3), 3);
                chk("lat3 rsp_id", 32'(rsp_id3), 0);
                chk("lat3 busy done", 32'(busy3), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
